// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a req/ack data-memory FSM, branch resolve and the MEM/WB register.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_regWrite_ex_mem,
  input  logic              ctrl_memToReg_ex_mem,
  input  logic              ctrl_branch_ex_mem,
  input  logic              ctrl_memRead_ex_mem,
  input  logic              ctrl_memWrite_ex_mem,
  input  logic              zero_ex_mem,
  input  logic [DATA_W-1:0] branch_or_not_address_ex_mem,
  input  logic [DATA_W-1:0] alu_result_ex_mem,
  input  logic [DATA_W-1:0] read_data_2_ex_mem,
  input  logic [REG_W-1:0]  write_register_ex_mem,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              mem_stall,
  output logic              ctrl_regWrite_mem_wb,
  output logic              ctrl_memToReg_mem_wb,
  output logic [DATA_W-1:0] read_data_mem_wb,
  output logic [DATA_W-1:0] alu_result_mem_wb,
  output logic [REG_W-1:0]  write_register_mem_wb,
  output logic [1:0]        mem_exc_mem_wb
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic mem_op, aligned, start, misaligned, done, abort;
  assign mem_op        = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
  assign aligned       = alu_result_ex_mem[1:0] == 2'b00;
  assign start         = state == IDLE && mem_op && aligned;
  assign misaligned    = state == IDLE && mem_op && !aligned;
  assign done          = state == REQ && dmem_ack;
  assign abort         = state == REQ && !dmem_ack && cnt == CNT_W'(TIMEOUT - 1);
  assign mem_stall     = state == IDLE ? start : !(done || abort);
  assign dmem_req      = state == REQ;
  assign pc_src        = ctrl_branch_ex_mem & zero_ex_mem;
  assign branch_target = branch_or_not_address_ex_mem;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state                 <= IDLE;
      cnt                   <= '0;
      dmem_we               <= 1'b0;
      dmem_addr             <= '0;
      dmem_wdata            <= '0;
      ctrl_regWrite_mem_wb  <= 1'b0;
      ctrl_memToReg_mem_wb  <= 1'b0;
      read_data_mem_wb      <= '0;
      alu_result_mem_wb     <= '0;
      write_register_mem_wb <= '0;
      mem_exc_mem_wb        <= 2'b00;
    end else begin
      if (start) begin
        state      <= REQ;
        cnt        <= '0;
        dmem_we    <= ctrl_memWrite_ex_mem;
        dmem_addr  <= alu_result_ex_mem;
        dmem_wdata <= read_data_2_ex_mem;
      end else if (state == REQ) begin
        state <= done || abort ? IDLE : REQ;
        cnt   <= cnt + 1'b1;
      end
      // a bubble clears only the control bits; data fields keep their last values
      if (mem_stall) begin
        ctrl_regWrite_mem_wb <= 1'b0;
        ctrl_memToReg_mem_wb <= 1'b0;
        mem_exc_mem_wb       <= 2'b00;
      end else begin
        ctrl_regWrite_mem_wb  <= ctrl_regWrite_ex_mem && !misaligned && !abort;
        ctrl_memToReg_mem_wb  <= ctrl_memToReg_ex_mem;
        read_data_mem_wb      <= done && !dmem_we ? dmem_rdata : '0;
        alu_result_mem_wb     <= alu_result_ex_mem;
        write_register_mem_wb <= write_register_ex_mem;
        mem_exc_mem_wb        <= misaligned ? 2'b01 : abort ? 2'b10 : 2'b00;
      end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: random instruction stream against a per-instruction model of the MEM stage, plus directed cases.
module tb_mem_stage;
  localparam int TO = 5;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  logic rw_i, m2r_i, br_i, zero_i, rd_i, wr_i, dmem_ack;
  logic [31:0] bta_i, alu_i, d2_i, dmem_rdata;
  logic [4:0] wreg_i;
  logic dmem_req, dmem_we, pc_src, mem_stall, rw_o, m2r_o;
  logic [31:0] dmem_addr, dmem_wdata, branch_target, rd_o, alu_o;
  logic [4:0] wreg_o;
  logic [1:0] exc_o;
  mem_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .ctrl_regWrite_ex_mem(rw_i), .ctrl_memToReg_ex_mem(m2r_i), .ctrl_branch_ex_mem(br_i),
    .ctrl_memRead_ex_mem(rd_i), .ctrl_memWrite_ex_mem(wr_i), .zero_ex_mem(zero_i),
    .branch_or_not_address_ex_mem(bta_i), .alu_result_ex_mem(alu_i), .read_data_2_ex_mem(d2_i),
    .write_register_ex_mem(wreg_i), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .pc_src(pc_src),
    .branch_target(branch_target), .mem_stall(mem_stall), .ctrl_regWrite_mem_wb(rw_o),
    .ctrl_memToReg_mem_wb(m2r_o), .read_data_mem_wb(rd_o), .alu_result_mem_wb(alu_o),
    .write_register_mem_wb(wreg_o), .mem_exc_mem_wb(exc_o)
  );
  typedef struct {
    logic stall, req, we, pc, rw, m2r;
    logic [31:0] addr, wdata, bt, rd, alu;
    logic [4:0] wr;
    logic [1:0] exc;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int total = 0, bad = 0, req_cnt = 0, stall_cnt = 0;
  bit chk_en = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    req_cnt += int'(dmem_req);
    stall_cnt += int'(mem_stall);
  end
  always begin
    @(negedge clk);
    if (chk_en && q.size() > 0) begin
      chk("mem_stall", mem_stall, q[0].stall);
      chk("dmem_req", dmem_req, q[0].req);
      chk("pc_src", pc_src, q[0].pc);
      chk("branch_target", branch_target, q[0].bt);
      if (q[0].req) begin
        chk("dmem_addr", dmem_addr, q[0].addr);
        chk("dmem_we", dmem_we, q[0].we);
        chk("dmem_wdata", dmem_wdata, q[0].wdata);
      end
      @(posedge clk);
      #1;
      chk("wb_regWrite", rw_o, q[0].rw);
      chk("wb_memToReg", m2r_o, q[0].m2r);
      chk("wb_read_data", rd_o, q[0].rd);
      chk("wb_alu_result", alu_o, q[0].alu);
      chk("wb_write_register", wreg_o, q[0].wr);
      chk("wb_exc", exc_o, q[0].exc);
      void'(q.pop_front());
    end
  end
  // One instruction held in EX/MEM until it leaves; lat = REQ cycles before ack (>= TO means no ack).
  task automatic run(input logic rw, m2r, br, z, rd, wr, input logic [31:0] bta, alu, d2,
                     input logic [4:0] wreg, input int lat, input logic [31:0] rdata);
    bit access = (rd || wr) && alu[1:0] == 2'b00;
    bit mis = (rd || wr) && alu[1:0] != 2'b00;
    bit acked = lat < TO;
    int n = access ? (acked ? lat + 2 : TO + 1) : 1;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      bit ack_now = (access && k > 0) ? (acked && k - 1 == lat) : 1'($urandom_range(0, 1));
      {rw_i, m2r_i, br_i, zero_i, rd_i, wr_i} = {rw, m2r, br, z, rd, wr};
      {bta_i, alu_i, d2_i, wreg_i} = {bta, alu, d2, wreg};
      dmem_ack = ack_now;
      dmem_rdata = (access && ack_now) ? rdata : $urandom;
      e.stall = access && k < n - 1;
      e.req = access && k > 0;
      e.we = wr;
      e.addr = alu;
      e.wdata = d2;
      e.pc = br & z;
      e.bt = bta;
      if (e.stall) begin
        m.rw = 0;
        m.m2r = 0;
        m.exc = 2'b00;
      end else begin
        m.rw = rw && !mis && !(access && !acked);
        m.m2r = m2r;
        m.rd = (access && acked && !wr) ? rdata : 32'h0;
        m.alu = alu;
        m.wr = wreg;
        m.exc = mis ? 2'b01 : (access && !acked) ? 2'b10 : 2'b00;
      end
      {e.rw, e.m2r, e.rd, e.alu, e.wr, e.exc} = {m.rw, m.m2r, m.rd, m.alu, m.wr, m.exc};
      q.push_back(e);
      @(posedge clk);
      #2;
    end
  endtask
  int s0, r0;
  initial begin
    {rw_i, m2r_i, br_i, zero_i, rd_i, wr_i, dmem_ack} = '0;
    {bta_i, alu_i, d2_i, wreg_i, dmem_rdata} = '0;
    #1;
    chk("rst dmem_req", dmem_req, 0);
    chk("rst dmem_we", dmem_we, 0);
    chk("rst dmem_addr", dmem_addr, 0);
    chk("rst dmem_wdata", dmem_wdata, 0);
    chk("rst wb_regWrite", rw_o, 0);
    chk("rst wb_read_data", rd_o, 0);
    chk("rst wb_exc", exc_o, 0);
    @(posedge clk);
    #2;
    reset = 1;
    m = '{default: 0};
    chk_en = 1;
    run(1, 0, 0, 0, 0, 0, 32'h0, 32'h10, 32'h0, 5'd5, 0, 32'h0);
    chk("add regWrite", rw_o, 1);
    chk("add alu_result", alu_o, 32'h10);
    chk("add write_register", wreg_o, 5);
    chk("add exc", exc_o, 0);
    s0 = stall_cnt; r0 = req_cnt;
    run(1, 1, 0, 0, 1, 0, 32'h0, 32'h100, 32'h0, 5'd7, 0, 32'hDEADBEEF);
    chk("load read_data", rd_o, 32'hDEADBEEF);
    chk("load memToReg", m2r_o, 1);
    chk("load stall cycles", stall_cnt - s0, 1);
    chk("load req cycles", req_cnt - r0, 1);
    s0 = stall_cnt; r0 = req_cnt;
    run(0, 0, 0, 0, 0, 1, 32'h0, 32'h200, 32'h12345678, 5'd0, 4, 32'h0);
    chk("store stall cycles", stall_cnt - s0, 5);
    chk("store req cycles", req_cnt - r0, 5);
    chk("store regWrite", rw_o, 0);
    chk("store exc", exc_o, 0);
    s0 = stall_cnt; r0 = req_cnt;
    run(1, 1, 0, 0, 1, 0, 32'h0, 32'h103, 32'h0, 5'd2, 0, 32'h0);
    chk("misaligned req cycles", req_cnt - r0, 0);
    chk("misaligned stall cycles", stall_cnt - s0, 0);
    chk("misaligned regWrite", rw_o, 0);
    chk("misaligned exc", exc_o, 1);
    r0 = req_cnt;
    run(1, 1, 0, 0, 1, 0, 32'h0, 32'h300, 32'h0, 5'd9, 99, 32'hCAFEF00D);
    chk("timeout req cycles", req_cnt - r0, TO);
    chk("timeout regWrite", rw_o, 0);
    chk("timeout exc", exc_o, 2);
    chk("timeout read_data", rd_o, 0);
    for (int i = 0; i < 200; i++) begin
      int kind = $urandom_range(0, 3);
      logic [31:0] a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      run(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), kind[0], kind[1],
          $urandom, a, $urandom, 5'($urandom), $urandom_range(0, TO + 1), $urandom);
    end
    chk_en = 0;
    {rw_i, m2r_i, br_i, zero_i, rd_i, wr_i, dmem_ack} = 7'b1110100;
    alu_i = 32'h400;
    @(posedge clk);
    #2;
    chk("pre-reset dmem_req", dmem_req, 1);
    {rw_i, m2r_i, br_i, zero_i, rd_i, wr_i} = '0;
    #1 reset = 0;
    #1;
    chk("async rst dmem_req", dmem_req, 0);
    chk("async rst dmem_addr", dmem_addr, 0);
    chk("async rst wb_regWrite", rw_o, 0);
    chk("async rst wb_alu_result", alu_o, 0);
    dmem_ack = 1;
    dmem_rdata = 32'h55;
    @(posedge clk);
    #2 reset = 1;
    @(posedge clk);
    #2;
    chk("late ack read_data", rd_o, 0);
    chk("late ack dmem_req", dmem_req, 0);
    br_i = 1;
    zero_i = 1;
    #1;
    chk("pc_src after reset", pc_src, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
